// File: rtl/program_loader.sv
`timescale 1ns/1ps
// program_loader: receives a program as a byte stream (high byte first),
// packs byte pairs into 16-bit words and writes them to consecutive memory
// addresses. While a load is in progress it drives the memory port (busy=1)
// and holds the processor in reset. The processor is released only after a
// load has completed.
module program_loader #(
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b0}},
  parameter int unsigned       LEN_W      = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [15:0]      mem_data_out,
  output logic [15:0]      mem_addr,
  output logic             rw,
  output logic             proc_reset,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   index_q, index_d;
  logic [7:0]         hi_q, hi_d;
  logic [15:0]        data_q, data_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rw_q, rw_d;
  logic               byte_ready_q, byte_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               proc_reset_q, proc_reset_d;

  logic [LEN_W-1:0]   next_index_s;
  logic [ADDR_W-1:0]  wr_addr_s;

  // Word counter step and target address; the address wraps naturally at 2^ADDR_W.
  always_comb begin
    next_index_s = index_q + {{(LEN_W-1){1'b0}}, 1'b1};
    wr_addr_s    = START_ADDR + index_q[ADDR_W-1:0];
  end

  // Next-state logic: byte capture, word assembly and load sequencing.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    index_d = index_q;
    hi_d    = hi_q;
    data_d  = data_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d   = length;
          index_d = {LEN_W{1'b0}};
          if (length == {LEN_W{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_HI;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_HI: begin
        if (byte_valid) begin
          hi_d    = byte_in;
          state_d = S_LO;
        end else begin
          state_d = S_HI;
        end
      end
      S_LO: begin
        if (byte_valid) begin
          // Word and address are loaded here so they are stable for the whole WRITE cycle.
          data_d  = {hi_q, byte_in};
          addr_d  = wr_addr_s;
          state_d = S_WRITE;
        end else begin
          state_d = S_LO;
        end
      end
      S_WRITE: begin
        index_d = next_index_s;
        if (next_index_s == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_HI;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flags decoded from the next state so they register alongside it.
  always_comb begin
    rw_d         = 1'b1;
    byte_ready_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    proc_reset_d = 1'b1;
    case (state_d)
      S_HI, S_LO: begin
        byte_ready_d = 1'b1;
        busy_d       = 1'b1;
      end
      S_WRITE: begin
        rw_d   = 1'b0;
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d       = 1'b1;
        proc_reset_d = 1'b0;
      end
      default: begin
        rw_d         = 1'b1;
        proc_reset_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset parks the port in read/idle with the processor held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= {LEN_W{1'b0}};
      index_q      <= {LEN_W{1'b0}};
      hi_q         <= 8'h00;
      data_q       <= 16'h0000;
      addr_q       <= {ADDR_W{1'b0}};
      rw_q         <= 1'b1;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      proc_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      index_q      <= index_d;
      hi_q         <= hi_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      proc_reset_q <= proc_reset_d;
    end
  end

  assign rw           = rw_q;
  assign byte_ready   = byte_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign proc_reset   = proc_reset_q;
  assign mem_data_out = data_q;
  assign mem_addr     = {{(16-ADDR_W){1'b0}}, addr_q};

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
// Testbench for program_loader: two instances (START_ADDR 0x00 and 0xFF)
// share one stimulus stream; a scoreboard queue per instance holds expected
// memory writes and a monitor pops them whenever rw=0.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  length;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        byte_ready0, rw0, proc_reset0, busy0, done0;
  logic [15:0] data0, addr0;
  logic        byte_ready1, rw1, proc_reset1, busy1, done1;
  logic [15:0] data1, addr1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [15:0] mem0[256];
  logic [15:0] mem1[256];

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(8), .START_ADDR(8'h00), .LEN_W(9)) dut0 (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready0),
    .mem_data_out(data0), .mem_addr(addr0), .rw(rw0),
    .proc_reset(proc_reset0), .busy(busy0), .done(done0)
  );

  program_loader #(.ADDR_W(8), .START_ADDR(8'hFF), .LEN_W(9)) dut1 (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready1),
    .mem_data_out(data1), .mem_addr(addr1), .rw(rw1),
    .proc_reset(proc_reset1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for instance 0: every write cycle must match the oldest expectation.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rw0 !== 1'b1) begin
        if (exp_q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL write0_unexpected: got addr %h data %h, required no write", addr0, data0);
        end else begin
          e = exp_q0.pop_front();
          check("write0_addr", {16'h0000, addr0}, {16'h0000, e[31:16]});
          check("write0_data", {16'h0000, data0}, {16'h0000, e[15:0]});
          check("write0_busy", {31'd0, busy0}, 32'd1);
        end
        mem0[addr0[7:0]] = data0;
      end
    end
  end

  // Monitor for instance 1.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rw1 !== 1'b1) begin
        if (exp_q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL write1_unexpected: got addr %h data %h, required no write", addr1, data1);
        end else begin
          e = exp_q1.pop_front();
          check("write1_addr", {16'h0000, addr1}, {16'h0000, e[31:16]});
          check("write1_data", {16'h0000, data1}, {16'h0000, e[15:0]});
        end
        mem1[addr1[7:0]] = data1;
      end
    end
  end

  task automatic do_start(input int len);
    length = len[8:0];
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic idle_cycles(input int g);
    byte_valid = 1'b0;
    repeat (g) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got        = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (byte_ready0 === 1'b1) got = 1'b1;
    end
    check("byte_ready_timeout", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  // Push the expected writes for both instances, from the address rules.
  task automatic expect_words(input int len, input logic [7:0] bytes[$]);
    for (int i = 0; i < len; i++) begin
      exp_q0.push_back({8'h00, 8'(i % 256), bytes[2*i], bytes[2*i+1]});
      exp_q1.push_back({8'h00, 8'((255 + i) % 256), bytes[2*i], bytes[2*i+1]});
    end
  endtask

  // mode 0: random gaps, 1: fixed bytes 12 34 AB CD, 2: 5-cycle stall in LO,
  // 3: start pulse while in LO.
  task automatic run_load(input int len, input int mode);
    logic [7:0] bytes[$];
    bit         seen;
    bytes = {};
    for (int i = 0; i < 2*len; i++) bytes.push_back(8'($urandom_range(0, 255)));
    if (mode == 1) bytes = {8'h12, 8'h34, 8'hAB, 8'hCD};
    expect_words(len, bytes);
    do_start(len);
    check("start_done_cleared", {31'd0, done0}, 32'd0);
    check("start_proc_reset", {31'd0, proc_reset0}, 32'd1);
    check("start_busy", {30'd0, busy1, busy0}, 32'd3);
    for (int i = 0; i < len; i++) begin
      send_byte(bytes[2*i]);
      if (mode == 2 && i == 0) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_rw", {31'd0, rw0}, 32'd1);
          check("stall_ready", {31'd0, byte_ready0}, 32'd1);
          @(posedge clk); #1;
        end
      end
      if (mode == 3 && i == 0) begin
        length = 9'd7;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        length = 9'd0;
        check("lo_start_ignored_busy", {31'd0, busy0}, 32'd1);
        check("lo_start_ignored_done", {31'd0, done0}, 32'd0);
      end
      if (mode == 0) idle_cycles($urandom_range(0, 2));
      send_byte(bytes[2*i+1]);
      if (mode == 0) idle_cycles($urandom_range(0, 2));
    end
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      if (done0 === 1'b1) seen = 1'b1;
    end
    check("done_timeout", {31'd0, seen}, 32'd1);
    check("end_proc_reset", {30'd0, proc_reset1, proc_reset0}, 32'd0);
    check("end_busy", {31'd0, busy0}, 32'd0);
    check("end_ready", {31'd0, byte_ready0}, 32'd0);
    check("end_rw", {31'd0, rw0}, 32'd1);
    check("end_done1", {31'd0, done1}, 32'd1);
    check("end_queue0_empty", exp_q0.size(), 32'd0);
    check("end_queue1_empty", exp_q1.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb[$];
    reset      = 1'b1;
    start      = 1'b0;
    length     = 9'd0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    foreach (mem0[i]) mem0[i] = 16'h0000;
    foreach (mem1[i]) mem1[i] = 16'h0000;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rw", {31'd0, rw0}, 32'd1);
    check("rst_addr", {16'h0000, addr0}, 32'd0);
    check("rst_data", {16'h0000, data0}, 32'd0);
    check("rst_ready", {31'd0, byte_ready0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_proc_reset", {31'd0, proc_reset0}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Zero-length load from IDLE: done the next cycle, no write
    check("idle_done", {31'd0, done0}, 32'd0);
    do_start(0);
    check("len0_done", {31'd0, done0}, 32'd1);
    check("len0_proc_reset", {31'd0, proc_reset0}, 32'd0);
    check("len0_busy", {31'd0, busy0}, 32'd0);
    idle_cycles(3);
    check("len0_rw", {31'd0, rw0}, 32'd1);

    // Fixed two-word load, then stall, then start-in-LO, then reload from DONE
    run_load(2, 1);
    check("t1_mem0", {mem0[0], mem0[1]}, 32'h1234ABCD);
    check("t1_mem1", {mem1[255], mem1[0]}, 32'h1234ABCD);
    run_load(3, 2);
    run_load(2, 3);
    run_load(4, 0);

    // Randomised loads
    for (int t = 0; t < 8; t++) run_load($urandom_range(1, 40), 0);
    run_load(256, 0);

    // Reset between the bytes of word 2: only word 1 lands in memory
    foreach (mem0[i]) mem0[i] = 16'h0000;
    foreach (mem1[i]) mem1[i] = 16'h0000;
    rb = {8'hBE, 8'hEF, 8'h42, 8'h99, 8'h55, 8'h66};
    expect_words(3, rb);
    do_start(3);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h42);
    idle_cycles(1);
    reset = 1'b1;
    #1;
    check("mid_rst_rw", {30'd0, rw1, rw0}, 32'd3);
    check("mid_rst_proc_reset", {30'd0, proc_reset1, proc_reset0}, 32'd3);
    check("mid_rst_busy", {31'd0, busy0}, 32'd0);
    check("mid_rst_ready", {31'd0, byte_ready0}, 32'd0);
    check("mid_rst_mem0", {mem0[0], mem0[1]}, 32'hBEEF0000);
    check("mid_rst_mem1", {mem1[255], mem1[0]}, 32'hBEEF0000);
    check("mid_rst_pending", exp_q0.size(), 32'd2);
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Recovery load after reset
    run_load(1, 0);
    run_load(5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
